// File: rtl/mem_access_stage.sv
// Data-memory access stage for the RV64I pipeline.
// Converts EX/MEM load/store control into req/ack transactions on a
// variable-latency 64-bit data port, extends load data and stalls the pipe
// while a transaction is outstanding.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses raise
// mem_fault instead of being force-aligned).
module mem_access_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic [2:0]  Funct3,
  input  logic [63:0] ALUResult,
  input  logic [63:0] StoreData,
  input  logic [4:0]  WriteReg,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_be,
  output logic [63:0] ReadData,
  output logic [63:0] ReadData2,
  output logic [4:0]  OutWriteReg,
  output logic        OutMemtoReg,
  output logic        OutRegWrite,
  output logic        maintain,
  output logic        mem_fault
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic        access;
  logic        start;
  logic        trap;
  logic [1:0]  size;
  logic [2:0]  align_mask;
  logic [2:0]  off;
  logic [63:0] wdata_n;
  logic [7:0]  be_n;
  logic [63:0] lane;
  logic [63:0] load_ext;
  logic [63:0] read_q;

  assign access = MemRead | MemWrite;
  assign size   = Funct3[1:0];

  // Low address bits that must be zero for a naturally aligned access.
  always_comb begin
    case (size)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
  logic fault_q;

  assign misalign = |(ALUResult[2:0] & align_mask);
  assign off      = ALUResult[2:0];
  assign trap     = (state == IDLE) && access && misalign;

  // Fault flag is a one-cycle registered pulse after the trapping access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fault_q <= 1'b0;
    else          fault_q <= trap;
  end
  assign mem_fault = fault_q;
`else
  assign off       = ALUResult[2:0] & ~align_mask;
  assign trap      = 1'b0;
  assign mem_fault = 1'b0;
`endif

  assign start = (state == IDLE) && access && !trap;

  // Stall whenever a transaction is starting or outstanding; forced low in reset.
  assign maintain = reset_n && (start || (state == BUSY));

  // Store lane replication and byte-enable generation.
  always_comb begin
    wdata_n = '0;
    be_n    = '0;
    case (size)
      2'd0: begin wdata_n = {8{StoreData[7:0]}};  be_n = 8'h01 << off; end
      2'd1: begin wdata_n = {4{StoreData[15:0]}}; be_n = 8'h03 << off; end
      2'd2: begin wdata_n = {2{StoreData[31:0]}}; be_n = 8'h0F << off; end
      default: begin wdata_n = StoreData;         be_n = 8'hFF;        end
    endcase
  end

  // Load lane selection and sign/zero extension from the returning doubleword.
  always_comb begin
    lane     = dmem_rdata >> {off, 3'b000};
    load_ext = lane;
    case (Funct3)
      3'b000:  load_ext = {{56{lane[7]}},  lane[7:0]};
      3'b001:  load_ext = {{48{lane[15]}}, lane[15:0]};
      3'b010:  load_ext = {{32{lane[31]}}, lane[31:0]};
      3'b100:  load_ext = {56'd0, lane[7:0]};
      3'b101:  load_ext = {48'd0, lane[15:0]};
      3'b110:  load_ext = {32'd0, lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: IDLE -> BUSY on access, BUSY -> DONE on ack, DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = BUSY;
      BUSY:    if (dmem_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request fields latched at start and held until ack; load result captured on ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      read_q     <= '0;
    end else if (start) begin
      dmem_req   <= 1'b1;
      dmem_we    <= MemWrite;
      dmem_addr  <= {ALUResult[63:3], 3'b000};
      dmem_wdata <= wdata_n;
      dmem_be    <= be_n;
    end else if ((state == BUSY) && dmem_ack) begin
      dmem_req   <= 1'b0;
      read_q     <= dmem_we ? '0 : load_ext;
    end
  end

  assign ReadData    = (state == DONE) ? read_q : '0;
  assign ReadData2   = ALUResult;
  assign OutWriteReg = WriteReg;
  assign OutMemtoReg = MemtoReg;
  assign OutRegWrite = RegWrite & ~trap;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Data-memory access stage of the 64-bit RV64I pipeline, between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns load/store control from EX/MEM into req/ack transactions on a variable-latency 64-bit data-memory port. It sign- or zero-extends load data into `ReadData`. Its `maintain` output stalls the pipeline while a transaction is in flight, and drives the `maintain` input of the MEM/WB register.

## Interface
- No parameters; the data path is fixed at 64 bits.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `MemRead`, `MemWrite`, `MemtoReg`, `RegWrite` in 1 each: control bits from EX/MEM.
- `Funct3` in 3: access size and sign.
- `ALUResult` in 64: effective address.
- `StoreData` in 64: store source register value.
- `WriteReg` in 5: destination register.
- `dmem_rdata` in 64: memory read data, valid when `dmem_ack`=1.
- `dmem_ack` in 1: one-cycle completion pulse from memory.
- `dmem_req` out 1: transaction request.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 64: doubleword address; bits [2:0] are always 0.
- `dmem_wdata` out 64: lane-replicated store data.
- `dmem_be` out 8: byte enables.
- `ReadData` out 64: extended load result, to MEM/WB.
- `ReadData2` out 64: `ALUResult` pass-through, to MEM/WB.
- `OutWriteReg` out 5, `OutMemtoReg` out 1, `OutRegWrite` out 1: control pass-through, to MEM/WB.
- `maintain` out 1: stall; holds PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- `mem_fault` out 1: misaligned access flag (only with macro).

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Access = `MemRead` | `MemWrite`. If both are 1, the access is a write.
- IDLE, no access: `maintain`=0; pass-through fields flow combinationally to MEM/WB. No stall.
- IDLE, access: `maintain`=1 combinationally this cycle. Latch address, byte enables, write data and `we`. Next state is BUSY.
- BUSY: `dmem_req`=1, `maintain`=1.
  - Address, write data, `be` and `we` are held stable until `dmem_ack`.
  - On `dmem_ack`: capture `dmem_rdata`, then go to DONE.
- DONE: `maintain`=0 and `ReadData` is valid; MEM/WB latches on this edge. Next state is IDLE.
- An access present in IDLE in the cycle after DONE is a new instruction, because EX/MEM advanced on the DONE edge.
- Load extraction: byte offset = `ALUResult`[2:0]; lane selects from the captured doubleword.
  - Funct3 000 LB and 001 LH: sign-extend.
  - Funct3 010 LW: sign-extend.
  - Funct3 011 LD: no extension.
  - Funct3 100 LBU, 101 LHU, 110 LWU: zero-extend.
  - Funct3 111: treated as LD.
- Store lanes:
  - SB: byte replicated ×8; `be` = 1<<off.
  - SH: half replicated ×4; `be` = 0x03<<off.
  - SW: word replicated ×2; `be` = 0x0F<<off.
  - SD: `be` = 0xFF.
- `ReadData` is 0 after a store and for non-memory instructions.
- `OutRegWrite` follows `RegWrite`, except for the fault case below.

## Timing
- Reset values: `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `dmem_be`=0, `ReadData`=0, `maintain`=0, `mem_fault`=0.
- Pass-through outputs (`ReadData2`, `OutWriteReg`, `OutMemtoReg`, `OutRegWrite`) follow their inputs combinationally, so they read 0 only when those inputs are 0.
- Access latency = N + 2 cycles, where N ≥ 1 is the number of BUSY cycles up to and including the ack. Minimum is 3 cycles: IDLE, BUSY with ack, DONE.
- `dmem_req` is registered and never asserted in IDLE or DONE.
- `dmem_ack` while not in BUSY is ignored.
- `reset_n` low mid-transaction:
  - FSM goes to IDLE immediately, and `dmem_req` and `maintain` drop asynchronously.
  - The outstanding transaction is abandoned; a late ack after reset is ignored.
- `maintain` is a combinational function of state and inputs only; it has no dependency on `dmem_rdata`.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - An access whose offset is not a multiple of its size issues no bus request and does not stall.
  - `mem_fault` pulses to 1 for one cycle, registered, on the following edge.
  - `OutRegWrite` is forced to 0 that cycle and `ReadData` is 0.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - Offset low bits are cleared to the natural alignment: LH/SH clear bit 0, LW/SW clear bits [1:0], LD/SD use offset 0.
  - The access then proceeds normally.
  - `mem_fault` is tied to 0.

## Test plan
- LD at 0x1000, `dmem_rdata`=0x8877665544332211, ack in the 1st BUSY cycle → `maintain`=1 for 2 cycles; in DONE, `ReadData`=0x8877665544332211 and `dmem_be` was 0xFF.
- LB at 0x1007 with `dmem_rdata`[63:56]=0x80 → `ReadData`=0xFFFFFFFFFFFFFF80. LBU at the same address → 0x0000000000000080.
- SH at 0x2002 with `StoreData`=0x1234, ack delayed 4 cycles → `dmem_we`=1, `dmem_be`=0x0C, `dmem_wdata`=0x1234123412341234 held for all 4 BUSY cycles; `maintain` high for 5 cycles.
- ADD with `RegWrite`=1 and `WriteReg`=5 → `maintain`=0, no `dmem_req`, `OutWriteReg`=5 in the same cycle.
- `reset_n` pulsed low in the 2nd BUSY cycle, then ack arrives → `dmem_req` and `maintain` drop at once; the late ack is ignored; state is IDLE and `ReadData`=0.
- LW at 0x3002:
  - With `MEM_MISALIGN_TRAP_EN`: `mem_fault`=1 for one cycle, no `dmem_req`, `OutRegWrite`=0.
  - Without it: request issued with `dmem_be`=0x0F.
